// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
// Scans a 4x4 passive matrix keypad. One column is pulled low at a time for
// SCAN_DIV cycles. The synchronized rows are sampled at the end of each column
// dwell. Each full scan is classified as NONE, KEY(k) or MULTI. A result must
// repeat for DEBOUNCE_SCANS consecutive scans before a press or a release is
// accepted.
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous active-high reset
//   row_in    keypad rows, active-low, asynchronous to clk
//   col_out   keypad column drive, active-low one-hot
//   key_code  last accepted key (row*4 + col), held until the next press
//   key_valid one-cycle pulse when a press is accepted
//   key_held  high while the accepted key is considered pressed
// -----------------------------------------------------------------------------
module keypad_scanner #(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DWELL_W = $clog2(SCAN_DIV);
    localparam int CNT_W   = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX    = CNT_W'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {RES_NONE, RES_KEY, RES_MULTI} res_class_t;
    typedef enum logic {IDLE, HELD} state_t;

    // ---------------- row synchronizer ----------------
    logic [3:0] row_meta_reg, row_sync_reg;
    logic [3:0] row_low;

    always_ff @(posedge clk) begin
        if (rst) begin
            row_meta_reg <= 4'b1111;
            row_sync_reg <= 4'b1111;
        end else begin
            row_meta_reg <= row_in;
            row_sync_reg <= row_meta_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_row_low
            assign row_low[gi] = ~row_sync_reg[gi];
        end
    endgenerate

    // ---------------- column dwell / drive ----------------
    logic [DWELL_W-1:0] dwell_reg;
    logic [1:0]         col_idx_reg;
    logic [1:0]         col_idx_next;
    logic [3:0]         col_out_reg;
    logic               sample_now;
    logic               scan_end;

    assign col_idx_next = col_idx_reg + 2'd1;
    assign sample_now   = (dwell_reg == DWELL_LAST);
    assign scan_end     = sample_now && (col_idx_reg == 2'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            dwell_reg   <= '0;
            col_idx_reg <= 2'd0;
            col_out_reg <= 4'b1110;
        end else if (sample_now) begin
            dwell_reg   <= '0;
            col_idx_reg <= col_idx_next;
            col_out_reg <= ~(4'b0001 << col_idx_next);
        end else begin
            dwell_reg <= dwell_reg + DWELL_W'(1);
        end
    end

    // ---------------- per-scan classification ----------------
    // acc_n counts low row bits seen so far in this scan, saturating at 2
    // (2 means "more than one", i.e. MULTI). acc_key remembers the single hit.
    logic [1:0] acc_n_reg;
    logic [3:0] acc_key_reg;
    logic [2:0] pc;
    logic [1:0] row_idx;
    logic [1:0] base_n;
    logic [2:0] sum_n;
    logic [1:0] n_final;
    logic [3:0] key_final;

    always_comb begin
        pc = {2'b00, row_low[0]} + {2'b00, row_low[1]}
           + {2'b00, row_low[2]} + {2'b00, row_low[3]};
        row_idx = 2'd0;
        for (int r = 3; r >= 0; r--) begin
            if (row_low[r]) row_idx = 2'(r);
        end
        // column 0 starts a fresh scan
        base_n  = (col_idx_reg == 2'd0) ? 2'd0 : acc_n_reg;
        sum_n   = {1'b0, base_n} + pc;
        n_final = (sum_n > 3'd1) ? 2'd2 : sum_n[1:0];
        key_final = (base_n == 2'd0 && pc == 3'd1) ? {row_idx, col_idx_reg} : acc_key_reg;
    end

    res_class_t scan_class_reg;
    logic [3:0] scan_key_reg;
    logic       scan_done_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_n_reg      <= 2'd0;
            acc_key_reg    <= 4'd0;
            scan_class_reg <= RES_NONE;
            scan_key_reg   <= 4'd0;
            scan_done_reg  <= 1'b0;
        end else begin
            scan_done_reg <= 1'b0;
            if (sample_now) begin
                acc_n_reg   <= n_final;
                acc_key_reg <= key_final;
            end
            if (scan_end) begin
                scan_done_reg <= 1'b1;
                scan_key_reg  <= key_final;
                case (n_final)
                    2'd0:    scan_class_reg <= RES_NONE;
                    2'd1:    scan_class_reg <= RES_KEY;
                    default: scan_class_reg <= RES_MULTI;
                endcase
            end
        end
    end

    // ---------------- stability count ----------------
    res_class_t       prev_class_reg, prev_class_next;
    logic [3:0]       prev_key_reg, prev_key_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             same_result;

    always_comb begin
        prev_class_next = prev_class_reg;
        prev_key_next   = prev_key_reg;
        count_next      = count_reg;
        same_result     = (scan_class_reg == prev_class_reg) &&
                          (scan_class_reg != RES_KEY || scan_key_reg == prev_key_reg);
        if (scan_done_reg) begin
            prev_class_next = scan_class_reg;
            prev_key_next   = scan_key_reg;
            if (scan_class_reg == RES_MULTI)
                count_next = '0;
            else if (same_result)
                count_next = (count_reg == CNT_MAX) ? CNT_MAX : count_reg + CNT_W'(1);
            else
                count_next = CNT_W'(1);
        end
    end

    // ---------------- press / release FSM ----------------
    state_t     state_reg, state_next;
    logic [3:0] key_code_reg, key_code_next;
    logic       key_valid_reg, key_valid_next;
    logic       key_held_reg, key_held_next;

    always_comb begin
        state_next     = state_reg;
        key_code_next  = key_code_reg;
        key_valid_next = 1'b0;
        key_held_next  = key_held_reg;
        if (scan_done_reg && count_next == CNT_MAX) begin
            case (state_reg)
                IDLE: if (scan_class_reg == RES_KEY) begin
                    state_next     = HELD;
                    key_code_next  = scan_key_reg;
                    key_valid_next = 1'b1;
                    key_held_next  = 1'b1;
                end
                HELD: if (scan_class_reg == RES_NONE) begin
                    state_next    = IDLE;
                    key_held_next = 1'b0;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_class_reg <= RES_NONE;
            prev_key_reg   <= 4'd0;
            count_reg      <= '0;
            state_reg      <= IDLE;
            key_code_reg   <= 4'd0;
            key_valid_reg  <= 1'b0;
            key_held_reg   <= 1'b0;
        end else begin
            prev_class_reg <= prev_class_next;
            prev_key_reg   <= prev_key_next;
            count_reg      <= count_next;
            state_reg      <= state_next;
            key_code_reg   <= key_code_next;
            key_valid_reg  <= key_valid_next;
            key_held_reg   <= key_held_next;
        end
    end

    assign col_out   = col_out_reg;
    assign key_code  = key_code_reg;
    assign key_valid = key_valid_reg;
    assign key_held  = key_held_reg;

endmodule

// File: tb/tb_keypad_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_scanner
// Drives a modelled 4x4 keypad against keypad_scanner (SCAN_DIV=8,
// DEBOUNCE_SCANS=3). Stimulus pushes expected key events (code and arrival
// cycle) into a queue; a monitor pops and compares on every key_valid pulse.
// One scan = 32 cycles. With a key pressed from the start of scan 1, the
// accepted event is visible 3*32+1 = 97 cycles after that scan's first cycle.
// -----------------------------------------------------------------------------
module tb_keypad_scanner;

    localparam int SCAN_DIV = 8;
    localparam int DEB      = 3;
    localparam int SCAN     = 4 * SCAN_DIV;
    localparam int LAT3     = 3 * SCAN + 1;   // 97
    localparam int LAT5     = 5 * SCAN + 1;   // 161 (bounce case)

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DEB)) dut (
        .clk       (clk),
        .rst       (rst),
        .row_in    (row_in),
        .col_out   (col_out),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // keypad model: key r*4+c pulls row r low while column c is driven low
    logic [15:0] pressed;
    always_comb begin
        row_in = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    typedef struct {
        logic [3:0] code;
        int         at;
    } exp_t;
    exp_t sb_q[$];

    // monitor: every key_valid pulse must match the head of the scoreboard
    always @(negedge clk) begin
        if (!rst && key_valid) begin
            $display("txn key_valid key_code=%0d cycle=%0d", key_code, cyc);
            if (sb_q.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("valid_code", key_code, e.code);
                chk("valid_cycle", cyc, e.at);
                chk("held_on_valid", key_held, 1);
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // returns at the negedge of the first cycle of a new scan (column 0)
    task automatic wait_scan_start();
        logic [3:0] prev;
        bit found = 0;
        for (int i = 0; i < 2 * SCAN && !found; i++) begin
            prev = col_out;
            @(negedge clk);
            if (col_out == 4'b1110 && prev == 4'b0111) found = 1;
        end
        chk("scan_start_seen", int'(found), 1);
    endtask

    int c0;

    initial begin
        rst = 1'b1;
        pressed = '0;
        wait_cycles(3);
        // reset state
        chk("rst_col_out", col_out, 4'b1110);
        chk("rst_key_code", key_code, 0);
        chk("rst_key_valid", key_valid, 0);
        chk("rst_key_held", key_held, 0);
        rst = 1'b0;
        c0 = cyc;

        // 1: idle column rotation
        chk("col0", col_out, 4'b1110);
        wait_cycles(SCAN_DIV); chk("col1", col_out, 4'b1101);
        wait_cycles(SCAN_DIV); chk("col2", col_out, 4'b1011);
        wait_cycles(SCAN_DIV); chk("col3", col_out, 4'b0111);
        wait_cycles(SCAN_DIV); chk("col_wrap", col_out, 4'b1110);
        wait_cycles(3 * SCAN);
        chk("idle_held", key_held, 0);

        // 2: key 9 held from a scan start, then 20 more scans with no repeat
        wait_scan_start();
        c0 = cyc;
        pressed[9] = 1'b1;
        sb_q.push_back('{code: 4'd9, at: c0 + LAT3});
        wait_cycles(23 * SCAN);
        chk("s2_queue_empty", sb_q.size(), 0);
        chk("s2_held", key_held, 1);
        chk("s2_code", key_code, 9);

        // 4: release, then press key 0
        wait_scan_start();
        c0 = cyc;
        pressed = '0;
        wait_cycles(LAT3 - 1);
        chk("s4_held_before", key_held, 1);
        wait_cycles(1);
        chk("s4_held_after", key_held, 0);
        chk("s4_code_kept", key_code, 9);
        wait_scan_start();
        c0 = cyc;
        pressed[0] = 1'b1;
        sb_q.push_back('{code: 4'd0, at: c0 + LAT3});
        wait_cycles(4 * SCAN);
        chk("s4_queue_empty", sb_q.size(), 0);
        chk("s4_code", key_code, 0);

        // 3: bounce on key 9 for two scans, then steady.
        // scan 1 sees it pressed, scan 2 released, scans 3..5 clean.
        pressed = '0;
        wait_cycles(5 * SCAN);
        chk("s3_idle", key_held, 0);
        wait_scan_start();
        c0 = cyc;
        sb_q.push_back('{code: 4'd9, at: c0 + LAT5});
        for (int t = 0; t < 2 * SCAN; t++) begin
            pressed[9] = ((t / 5) % 2 == 0);
            @(negedge clk);
        end
        pressed[9] = 1'b1;
        wait_cycles(6 * SCAN);
        chk("s3_queue_empty", sb_q.size(), 0);

        // 5: two keys together, then rollover attempt
        pressed = '0;
        wait_cycles(5 * SCAN);
        pressed[0]  = 1'b1;
        pressed[15] = 1'b1;
        wait_cycles(8 * SCAN);
        chk("s5_multi_no_held", key_held, 0);
        pressed = '0;
        wait_cycles(5 * SCAN);
        wait_scan_start();
        c0 = cyc;
        pressed[5] = 1'b1;
        sb_q.push_back('{code: 4'd5, at: c0 + LAT3});
        wait_cycles(4 * SCAN);
        chk("s5_queue_empty", sb_q.size(), 0);
        pressed[6] = 1'b1;
        wait_cycles(8 * SCAN);
        chk("s5_roll_held", key_held, 1);
        chk("s5_roll_code", key_code, 5);

        // 6: reset while key 9 is held
        pressed = '0;
        wait_cycles(5 * SCAN);
        wait_scan_start();
        c0 = cyc;
        pressed[9] = 1'b1;
        sb_q.push_back('{code: 4'd9, at: c0 + LAT3});
        wait_cycles(5 * SCAN + 13);
        chk("s6_pre_held", key_held, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("s6_rst_col_out", col_out, 4'b1110);
        chk("s6_rst_code", key_code, 0);
        chk("s6_rst_valid", key_valid, 0);
        chk("s6_rst_held", key_held, 0);
        rst = 1'b0;
        c0 = cyc;
        sb_q.push_back('{code: 4'd9, at: c0 + LAT3});
        wait_cycles(5 * SCAN);
        chk("s6_queue_empty", sb_q.size(), 0);
        chk("s6_code", key_code, 9);
        chk("s6_held", key_held, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog_timeout cycle=%0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
